// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: controller states and nibble width.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

endpackage

// File: rtl/nibble_serial_adder_rippleadder.sv
// Purely combinational 4-bit ripple-carry adder: one nibble plus carry-in per evaluation.
module rippleadder
  import adder_pkg::*;
(
  output logic [NIBBLE_W-1:0] sum,
  output logic                carry,
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                z
);

  logic [NIBBLE_W:0] c;

  assign c[0] = z;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    assign sum[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign carry = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-word adder that feeds one nibble per clock through rippleadder, carrying between
// nibbles in a register, with valid/ready handshakes on both operand and result sides.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH-1:0]   a_q, b_q, sum_q;
  logic               carry_q;
  logic [NIBBLE_W-1:0] nibA, nibB, nibSum;
  logic               nibCarry;
  logic               lastNib;

  assign nibA    = a_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
  assign nibB    = b_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
  assign lastNib = (idx_q == IDX_W'(NIB - 1));

  rippleadder u_rippleadder (
    .sum   (nibSum),
    .carry (nibCarry),
    .x     (nibA),
    .y     (nibB),
    .z     (carry_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (lastNib)   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    sum       = sum_q;
    cout      = carry_q;
  end

  // The index saturates on the last nibble so it never wraps past NIB-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W] <= nibSum;
          carry_q <= nibCarry;
          if (!lastNib) idx_q <= idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16): vector table plus handshake,
// backpressure, input-stall and mid-operation reset sequences.
module tb_nibble_serial_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] expSum;
    logic        expCout;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;

  int passCount;
  int checkCount;

  vec_t vecs[8];

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Present an operand pair and hold it until the accepting edge has passed.
  task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb, input logic vc);
    int n;
    a        = va;
    b        = vb;
    cin      = vc;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Count edges after acceptance until out_valid appears; bounded.
  task automatic waitResult(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    int lat;

    passCount  = 0;
    checkCount = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    a          = '0;
    b          = '0;
    cin        = 1'b0;

    vecs[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[4] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[6] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0};
    vecs[7] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};

    tick();
    tick();
    checkOutput("reset_in_ready",  32'(in_ready),  32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_sum",       32'(sum),       32'h0);
    checkOutput("reset_cout",      32'(cout),      32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin);
      waitResult(lat);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat),  32'd4);
      checkOutput($sformatf("vec%0d_sum", i),     32'(sum),  32'(vecs[i].expSum));
      checkOutput($sformatf("vec%0d_cout", i),    32'(cout), 32'(vecs[i].expCout));
      tick();
      checkOutput($sformatf("vec%0d_in_ready_after", i), 32'(in_ready), 32'd1);
    end

    // Backpressure: result must hold while downstream stalls.
    out_ready = 1'b0;
    applyStimulus(16'h00F0, 16'h0010, 1'b0);
    waitResult(lat);
    checkOutput("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_sum",       32'(sum),       32'h0100);
      checkOutput("bp_in_ready",  32'(in_ready),  32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    checkOutput("bp_release_out_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_release_in_ready",  32'(in_ready),  32'd1);

    // Input stall: a second pair offered during RUN must be ignored.
    applyStimulus(16'h1234, 16'h1111, 1'b0);
    a        = 16'hFFFF;
    b        = 16'hFFFF;
    cin      = 1'b1;
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    waitResult(lat);
    checkOutput("stall_latency", 32'(lat + 2), 32'd4);
    checkOutput("stall_sum",     32'(sum),     32'h2345);
    checkOutput("stall_cout",    32'(cout),    32'd0);
    tick();

    // Reset after two nibbles: the operation is discarded.
    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("midrst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_sum",       32'(sum),       32'h0);
    checkOutput("midrst_cout",      32'(cout),      32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("midrst_no_result", 32'(out_valid), 32'd0);
    end
    applyStimulus(16'h0001, 16'h0002, 1'b0);
    waitResult(lat);
    checkOutput("post_rst_latency", 32'(lat),  32'd4);
    checkOutput("post_rst_sum",     32'(sum),  32'h0003);
    checkOutput("post_rst_cout",    32'(cout), 32'd0);
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
